// File: rtl/alarm_controller.sv
// alarm_controller
// Holds the programmable alarm time and day mask. Compares them against the
// running current-time word every cycle. Runs the ring / snooze /
// auto-silence state machine that drives the buzzer. Snooze and ring
// durations are counted in clock minutes, which are detected as changes in
// the minute field of the incoming time word.

module alarm_controller #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 10
) (
    input  logic        Clk,
    input  logic        Clr_AL,
    input  logic [14:0] CT,
    input  logic [11:0] ATI,
    input  logic [6:0]  DMI,
    input  logic        LD_AT,
    input  logic        EN_AL,
    input  logic        SNZ,
    input  logic        OFF,
    output logic [11:0] ATO,
    output logic [6:0]  DMO,
    output logic        RING,
    output logic [1:0]  ST,
    output logic        AT_ERR
);

    typedef enum logic [1:0] {
        S_DISARMED = 2'b00,
        S_ARMED    = 2'b01,
        S_RINGING  = 2'b10,
        S_SNOOZE   = 2'b11
    } state_t;

    localparam logic [3:0] SNOOZE_LEN = 4'(SNOOZE_MIN);
    localparam logic [3:0] RING_LEN   = 4'(RING_MIN);

    state_t     state;
    logic [3:0] ring_cnt;
    logic [3:0] snz_cnt;
    logic [3:0] ring_inc;
    logic [3:0] snz_dec;
    logic       match;
    logic       match_q;
    logic       trigger;
    logic [6:0] ct_q;
    logic       primed;
    logic       minute_evt;
    logic       snz_q;
    logic       off_q;
    logic       snz_edge;
    logic       off_edge;
    logic       ati_legal;
    logic [7:0] dmo_ext;

    // Alarm compare, legality of the load value and all single-cycle events
    always_comb begin
        dmo_ext    = {1'b0, DMO};
        ati_legal  = (ATI[3:0] <= 4'd9) && (ATI[6:4] <= 3'd5) && (ATI[11:7] <= 5'd23);
        match      = (CT[11:0] == ATO) && dmo_ext[CT[14:12]];
        trigger    = match && !match_q;
        minute_evt = primed && (CT[6:0] != ct_q);
        snz_edge   = SNZ && !snz_q;
        off_edge   = OFF && !off_q;
        ring_inc   = ring_cnt + 4'd1;
        snz_dec    = snz_cnt - 4'd1;
    end

    assign ST = state;

    // Alarm time and day mask storage; an illegal time leaves them untouched and flags the error
    always_ff @(posedge Clk or posedge Clr_AL) begin
        if (Clr_AL) begin
            ATO    <= 12'd0;
            DMO    <= 7'd0;
            AT_ERR <= 1'b0;
        end else if (LD_AT) begin
            if (ati_legal) begin
                ATO    <= ATI;
                DMO    <= DMI;
                AT_ERR <= 1'b0;
            end else begin
                AT_ERR <= 1'b1;
            end
        end
    end

    // History registers for match, minute field and buttons; primed masks the first post-reset compare
    always_ff @(posedge Clk or posedge Clr_AL) begin
        if (Clr_AL) begin
            match_q <= 1'b0;
            ct_q    <= 7'd0;
            primed  <= 1'b0;
            snz_q   <= 1'b0;
            off_q   <= 1'b0;
        end else begin
            match_q <= match;
            ct_q    <= CT[6:0];
            primed  <= 1'b1;
            snz_q   <= SNZ;
            off_q   <= OFF;
        end
    end

    // Alarm state machine with registered buzzer output; EN_AL dominates, then OFF, then SNZ
    always_ff @(posedge Clk or posedge Clr_AL) begin
        if (Clr_AL) begin
            state    <= S_DISARMED;
            RING     <= 1'b0;
            ring_cnt <= 4'd0;
            snz_cnt  <= 4'd0;
        end else begin
            case (state)
                S_DISARMED: begin
                    RING <= 1'b0;
                    if (EN_AL) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!EN_AL) begin
                        state <= S_DISARMED;
                        RING  <= 1'b0;
                    end else if (trigger) begin
                        state    <= S_RINGING;
                        RING     <= 1'b1;
                        ring_cnt <= 4'd0;
                    end
                end
                S_RINGING: begin
                    if (!EN_AL) begin
                        state <= S_DISARMED;
                        RING  <= 1'b0;
                    end else if (off_edge) begin
                        state <= S_ARMED;
                        RING  <= 1'b0;
                    end else if (snz_edge) begin
                        state   <= S_SNOOZE;
                        RING    <= 1'b0;
                        snz_cnt <= SNOOZE_LEN;
                    end else if (minute_evt && (ring_cnt < RING_LEN)) begin
                        ring_cnt <= ring_inc;
                        if (ring_inc == RING_LEN) begin
                            state <= S_ARMED;
                            RING  <= 1'b0;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (!EN_AL) begin
                        state <= S_DISARMED;
                        RING  <= 1'b0;
                    end else if (off_edge) begin
                        state <= S_ARMED;
                        RING  <= 1'b0;
                    end else if (minute_evt && (snz_cnt != 4'd0)) begin
                        snz_cnt <= snz_dec;
                        if (snz_dec == 4'd0) begin
                            state    <= S_RINGING;
                            RING     <= 1'b1;
                            ring_cnt <= 4'd0;
                        end
                    end
                end
                default: begin
                    state <= S_DISARMED;
                    RING  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller
// Scoreboard bench: each stimulus step pushes the output word expected after
// the next clock edge, and a negedge monitor pops and compares it.

module tb_alarm_controller;

    logic        clk = 1'b0;
    logic        clr_al;
    logic [14:0] ct;
    logic [11:0] ati;
    logic [6:0]  dmi;
    logic        ld_at;
    logic        en_al;
    logic        snz;
    logic        off;
    logic [11:0] ato;
    logic [6:0]  dmo;
    logic        ring;
    logic [1:0]  st;
    logic        at_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle_count  = 0;

    logic [11:0] exp_ato;
    logic [6:0]  exp_dmo;
    logic        exp_err;

    string       exp_tag_q[$];
    logic [22:0] exp_val_q[$];
    int          exp_due_q[$];

    logic [22:0] obs;
    assign obs = {st, ring, at_err, dmo, ato};

    alarm_controller #(.SNOOZE_MIN(5), .RING_MIN(10)) dut (
        .Clk    (clk),
        .Clr_AL (clr_al),
        .CT     (ct),
        .ATI    (ati),
        .DMI    (dmi),
        .LD_AT  (ld_at),
        .EN_AL  (en_al),
        .SNZ    (snz),
        .OFF    (off),
        .ATO    (ato),
        .DMO    (dmo),
        .RING   (ring),
        .ST     (st),
        .AT_ERR (at_err)
    );

    always #5 clk = ~clk;

    // Cycle counter used to schedule when a pushed expectation becomes due
    always @(posedge clk) cycle_count <= cycle_count + 1;

    function automatic logic [11:0] mk_at(input int hour, input int minute);
        return {5'(hour), 3'(minute / 10), 4'(minute % 10)};
    endfunction

    function automatic logic [14:0] mk_ct(input int day, input int hour, input int minute);
        return {3'(day), mk_at(hour, minute)};
    endfunction

    task automatic checkOutput(input string tag, input logic [22:0] observed, input logic [22:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed st=%b ring=%b err=%b dmo=%h ato=%h, expected st=%b ring=%b err=%b dmo=%h ato=%h",
                     tag, observed[22:21], observed[20], observed[19], observed[18:12], observed[11:0],
                     expected[22:21], expected[20], expected[19], expected[18:12], expected[11:0]);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] exp_st);
        exp_tag_q.push_back(tag);
        exp_val_q.push_back({exp_st, (exp_st == 2'b10), exp_err, exp_dmo, exp_ato});
        exp_due_q.push_back(cycle_count + 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that has become due, away from the active edge
    always @(negedge clk) begin
        while (exp_due_q.size() > 0 && exp_due_q[0] <= cycle_count) begin
            string       t;
            logic [22:0] v;
            t = exp_tag_q.pop_front();
            v = exp_val_q.pop_front();
            void'(exp_due_q.pop_front());
            checkOutput(t, obs, v);
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr_al = 1'b1;
        ct     = mk_ct(2, 7, 29);
        ati    = 12'd0;
        dmi    = 7'd0;
        ld_at  = 1'b0;
        en_al  = 1'b0;
        snz    = 1'b0;
        off    = 1'b0;
        exp_ato = 12'd0;
        exp_dmo = 7'd0;
        exp_err = 1'b0;

        #3;
        checkOutput("reset", obs, 23'd0);
        @(posedge clk);
        #1;
        clr_al = 1'b0;

        // Load a legal alarm, then an illegal one
        ld_at = 1'b1; ati = mk_at(7, 30); dmi = 7'h7F;
        exp_ato = mk_at(7, 30); exp_dmo = 7'h7F; exp_err = 1'b0;
        applyStimulus("load_ok", 2'b00);
        ati = {5'd7, 3'd3, 4'd10}; dmi = 7'h00;
        exp_err = 1'b1;
        applyStimulus("load_bad", 2'b00);
        ld_at = 1'b0;

        // Arm and trigger
        en_al = 1'b1;
        applyStimulus("arm", 2'b01);
        ct = mk_ct(2, 7, 30);
        applyStimulus("trigger", 2'b10);

        // OFF stops ringing; no re-ring inside the matching minute
        off = 1'b1;
        applyStimulus("off", 2'b01);
        applyStimulus("off_hold1", 2'b01);
        applyStimulus("off_hold2", 2'b01);
        off = 1'b0; ct = mk_ct(2, 7, 31);
        applyStimulus("armed_minute", 2'b01);
        ct = mk_ct(2, 7, 30);
        applyStimulus("retrigger", 2'b10);

        // Snooze for five minute changes
        snz = 1'b1;
        applyStimulus("snooze", 2'b11);
        for (int i = 1; i <= 5; i++) begin
            snz = (i == 1);
            ct  = mk_ct(2, 7, 30 + i);
            applyStimulus($sformatf("snz_min%0d", i), (i == 5) ? 2'b10 : 2'b11);
        end

        // Auto-silence after ten minute changes of continuous ringing
        for (int i = 1; i <= 10; i++) begin
            ct = mk_ct(2, 7, 35 + i);
            applyStimulus($sformatf("ring_min%0d", i), (i == 10) ? 2'b01 : 2'b10);
        end

        // Priority: OFF beats SNZ, EN_AL=0 beats everything
        ct = mk_ct(2, 7, 30);
        applyStimulus("prio_ring", 2'b10);
        off = 1'b1; snz = 1'b1;
        applyStimulus("prio_off_snz", 2'b01);
        off = 1'b0; snz = 1'b0; ct = mk_ct(2, 7, 31);
        applyStimulus("prio_idle", 2'b01);
        ct = mk_ct(2, 7, 30);
        applyStimulus("prio_ring2", 2'b10);
        en_al = 1'b0; snz = 1'b1;
        applyStimulus("prio_en", 2'b00);
        en_al = 1'b1; snz = 1'b0;
        applyStimulus("rearm_no_ring", 2'b01);

        // Day mask: clear day 2, day 3 still rings, day 7 never matches
        ld_at = 1'b1; ati = mk_at(7, 30); dmi = 7'h7B;
        exp_dmo = 7'h7B; exp_err = 1'b0;
        applyStimulus("load_mask", 2'b01);
        ld_at = 1'b0; ct = mk_ct(2, 7, 31);
        applyStimulus("mask_idle", 2'b01);
        ct = mk_ct(2, 7, 30);
        applyStimulus("mask_no_ring", 2'b01);
        ct = mk_ct(3, 7, 30);
        applyStimulus("mask_day3", 2'b10);
        off = 1'b1;
        applyStimulus("mask_off", 2'b01);
        off = 1'b0; ct = mk_ct(3, 7, 31);
        applyStimulus("day7_prep", 2'b01);
        ct = mk_ct(7, 7, 30);
        applyStimulus("day7_no_ring", 2'b01);

        // Loading an alarm equal to the current time rings one cycle later
        ct = mk_ct(2, 7, 31);
        ld_at = 1'b1; ati = mk_at(7, 31); dmi = 7'h7F;
        exp_ato = mk_at(7, 31); exp_dmo = 7'h7F;
        applyStimulus("load_eq_ct", 2'b01);
        ld_at = 1'b0;
        applyStimulus("load_eq_ring", 2'b10);

        // Asynchronous reset between edges while ringing
        @(negedge clk);
        #2;
        clr_al = 1'b1;
        #1;
        checkOutput("async_rst", obs, 23'd0);
        #1;
        clr_al = 1'b0;
        exp_ato = 12'd0; exp_dmo = 7'd0; exp_err = 1'b0;
        applyStimulus("post_rst_arm", 2'b01);
        ct = mk_ct(2, 7, 32);
        applyStimulus("post_rst_hold", 2'b01);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("drain", 23'(exp_due_q.size()), 23'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
